// File: rtl/ula_issuer.sv
// ---------------------------------------------------------------------------
// ula_issuer
// Initiator side of the ula operand/result interface. Requests accepted on a
// valid/ready port are issued to a single ula instance (fixed 2-cycle latency,
// no backpressure). Returning results are matched to the in-order issued ops
// and buffered in a response FIFO together with the selector that made them.
//
// Optional build macro: ULA_ISSUER_CHECK_EN
//   When defined, every queued op also carries the result it should produce
//   and the output mismatch_o flags (sticky) any returned result that differs.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req_valid_i/req_ready_o     request handshake (ready = credit available)
//   req_a_i, req_b_i, req_sel_i request operands and operation
//   alu_valid_o, alu_data_1_o,
//   alu_data_2_o, alu_sel_o     issue port towards the ula
//   alu_valid_i, alu_data_i     result port from the ula
//   rsp_valid_o/rsp_ready_i     response handshake
//   rsp_data_o, rsp_sel_o       buffered result and its selector
//   busy_o                      ops in flight or responses buffered
//   proto_err_o                 sticky: result arrived with nothing in flight
//   mismatch_o                  (ULA_ISSUER_CHECK_EN only) sticky result check
// ---------------------------------------------------------------------------
module ula_issuer #(
   parameter int DATA_WIDTH = 8,
   parameter int SEL_WIDTH  = 2,
   parameter int RSP_DEPTH  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [DATA_WIDTH-1:0]   req_a_i,
   input  logic [DATA_WIDTH-1:0]   req_b_i,
   input  logic [SEL_WIDTH-1:0]    req_sel_i,
   output logic                    alu_valid_o,
   output logic [DATA_WIDTH-1:0]   alu_data_1_o,
   output logic [DATA_WIDTH-1:0]   alu_data_2_o,
   output logic [SEL_WIDTH-1:0]    alu_sel_o,
   input  logic                    alu_valid_i,
   input  logic [2*DATA_WIDTH-1:0] alu_data_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [2*DATA_WIDTH-1:0] rsp_data_o,
   output logic [SEL_WIDTH-1:0]    rsp_sel_o,
   output logic                    busy_o,
   output logic                    proto_err_o
`ifdef ULA_ISSUER_CHECK_EN
   ,
   output logic                    mismatch_o
`endif
);

   localparam int PW = $clog2(RSP_DEPTH);
   localparam int CW = PW + 1;
   localparam int RW = 2 * DATA_WIDTH;

   // issue register
   logic                  alu_valid_q, alu_valid_d;
   logic [DATA_WIDTH-1:0] alu_d1_q, alu_d1_d;
   logic [DATA_WIDTH-1:0] alu_d2_q, alu_d2_d;
   logic [SEL_WIDTH-1:0]  alu_sel_q, alu_sel_d;

   // op queue: selectors of ops accepted but not yet returned
   logic [SEL_WIDTH-1:0]  opq_sel_q [RSP_DEPTH];
   logic [SEL_WIDTH-1:0]  opq_sel_d [RSP_DEPTH];
   logic [PW-1:0]         opq_wr_q, opq_wr_d, opq_rd_q, opq_rd_d;
   logic [CW-1:0]         inflight_q, inflight_d;

   // response FIFO
   logic [RW-1:0]         rsp_mem_q [RSP_DEPTH];
   logic [RW-1:0]         rsp_mem_d [RSP_DEPTH];
   logic [SEL_WIDTH-1:0]  rsp_msel_q [RSP_DEPTH];
   logic [SEL_WIDTH-1:0]  rsp_msel_d [RSP_DEPTH];
   logic [PW-1:0]         rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
   logic [CW-1:0]         rsp_cnt_q, rsp_cnt_d;

   logic                  ready_en_q, ready_en_d;
   logic [2:0]            mask_cnt_q, mask_cnt_d;
   logic                  proto_err_q, proto_err_d;

   logic                  acc, ret, pop;
   logic [CW-1:0]         outstanding;

`ifdef ULA_ISSUER_CHECK_EN
   logic [RW-1:0]         opq_exp_q [RSP_DEPTH];
   logic [RW-1:0]         opq_exp_d [RSP_DEPTH];
   logic [RW-1:0]         exp_res;
   logic                  mismatch_q, mismatch_d;
`endif

   // Credit is purely a function of the counters; ready_en_q only keeps the
   // port low while reset is held.
   assign outstanding  = inflight_q + rsp_cnt_q;
   assign req_ready_o  = ready_en_q && (outstanding < CW'(RSP_DEPTH));
   assign alu_valid_o  = alu_valid_q;
   assign alu_data_1_o = alu_d1_q;
   assign alu_data_2_o = alu_d2_q;
   assign alu_sel_o    = alu_sel_q;
   assign rsp_valid_o  = (rsp_cnt_q != '0);
   assign rsp_data_o   = rsp_mem_q[rsp_rd_q];
   assign rsp_sel_o    = rsp_msel_q[rsp_rd_q];
   assign busy_o       = (outstanding != '0);
   assign proto_err_o  = proto_err_q;

`ifdef ULA_ISSUER_CHECK_EN
   assign mismatch_o = mismatch_q;

   always_comb begin
      exp_res = '0;
      if (req_sel_i == SEL_WIDTH'(0))
         exp_res = RW'(req_a_i) + RW'(req_b_i);
      else if (req_sel_i == SEL_WIDTH'(1))
         exp_res = RW'(req_a_i) - RW'(req_b_i);
      else if (req_sel_i == SEL_WIDTH'(2))
         exp_res = RW'(req_a_i) + RW'(1);
   end
`endif

   always_comb begin
      acc = req_valid_i & req_ready_o;
      // a result only pairs with an op if one is actually in flight
      ret = alu_valid_i & (inflight_q != '0);
      pop = rsp_valid_o & rsp_ready_i;

      alu_valid_d = acc;
      alu_d1_d    = acc ? req_a_i   : alu_d1_q;
      alu_d2_d    = acc ? req_b_i   : alu_d2_q;
      alu_sel_d   = acc ? req_sel_i : alu_sel_q;

      opq_sel_d   = opq_sel_q;
      opq_wr_d    = opq_wr_q;
      opq_rd_d    = opq_rd_q;
      rsp_mem_d   = rsp_mem_q;
      rsp_msel_d  = rsp_msel_q;
      rsp_wr_d    = rsp_wr_q;
      rsp_rd_d    = rsp_rd_q;
      ready_en_d  = 1'b1;
      mask_cnt_d  = mask_cnt_q;
      proto_err_d = proto_err_q;
`ifdef ULA_ISSUER_CHECK_EN
      opq_exp_d   = opq_exp_q;
      mismatch_d  = mismatch_q;
`endif

      if (acc) begin
         opq_sel_d[opq_wr_q] = req_sel_i;
`ifdef ULA_ISSUER_CHECK_EN
         opq_exp_d[opq_wr_q] = exp_res;
`endif
         opq_wr_d = opq_wr_q + PW'(1);
      end

      if (ret) begin
         rsp_mem_d[rsp_wr_q]  = alu_data_i;
         rsp_msel_d[rsp_wr_q] = opq_sel_q[opq_rd_q];
         rsp_wr_d = rsp_wr_q + PW'(1);
         opq_rd_d = opq_rd_q + PW'(1);
`ifdef ULA_ISSUER_CHECK_EN
         if (alu_data_i != opq_exp_q[opq_rd_q])
            mismatch_d = 1'b1;
`endif
      end

      if (pop)
         rsp_rd_d = rsp_rd_q + PW'(1);

      inflight_d = inflight_q + CW'(acc) - CW'(ret);
      rsp_cnt_d  = rsp_cnt_q + CW'(ret) - CW'(pop);

      // Stray results are silently dropped while the post-reset window is
      // open, so ops issued before a reset can drain out of the ula.
      if (alu_valid_i && (inflight_q == '0) && (mask_cnt_q == '0))
         proto_err_d = 1'b1;
      if (mask_cnt_q != '0)
         mask_cnt_d = mask_cnt_q - 3'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_valid_q <= 1'b0;
         alu_d1_q    <= '0;
         alu_d2_q    <= '0;
         alu_sel_q   <= '0;
         for (int i = 0; i < RSP_DEPTH; i++) begin
            opq_sel_q[i]  <= '0;
            rsp_mem_q[i]  <= '0;
            rsp_msel_q[i] <= '0;
`ifdef ULA_ISSUER_CHECK_EN
            opq_exp_q[i]  <= '0;
`endif
         end
         opq_wr_q    <= '0;
         opq_rd_q    <= '0;
         inflight_q  <= '0;
         rsp_wr_q    <= '0;
         rsp_rd_q    <= '0;
         rsp_cnt_q   <= '0;
         ready_en_q  <= 1'b0;
         mask_cnt_q  <= 3'd4;
         proto_err_q <= 1'b0;
`ifdef ULA_ISSUER_CHECK_EN
         mismatch_q  <= 1'b0;
`endif
      end else begin
         alu_valid_q <= alu_valid_d;
         alu_d1_q    <= alu_d1_d;
         alu_d2_q    <= alu_d2_d;
         alu_sel_q   <= alu_sel_d;
         opq_sel_q   <= opq_sel_d;
         rsp_mem_q   <= rsp_mem_d;
         rsp_msel_q  <= rsp_msel_d;
`ifdef ULA_ISSUER_CHECK_EN
         opq_exp_q   <= opq_exp_d;
         mismatch_q  <= mismatch_d;
`endif
         opq_wr_q    <= opq_wr_d;
         opq_rd_q    <= opq_rd_d;
         inflight_q  <= inflight_d;
         rsp_wr_q    <= rsp_wr_d;
         rsp_rd_q    <= rsp_rd_d;
         rsp_cnt_q   <= rsp_cnt_d;
         ready_en_q  <= ready_en_d;
         mask_cnt_q  <= mask_cnt_d;
         proto_err_q <= proto_err_d;
      end
   end

endmodule

// File: tb/tb_ula_issuer.sv
// ---------------------------------------------------------------------------
// tb_ula_issuer
// Directed bench for ula_issuer with a behavioural 2-cycle ula attached.
// Single-op vectors come from a table; back-pressure, protocol error,
// mid-operation reset and (with ULA_ISSUER_CHECK_EN) result corruption are
// hand-written sequences.
// ---------------------------------------------------------------------------
module tb_ula_issuer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [7:0]  req_a_i = '0;
   logic [7:0]  req_b_i = '0;
   logic [1:0]  req_sel_i = '0;
   logic        alu_valid_o;
   logic [7:0]  alu_data_1_o, alu_data_2_o;
   logic [1:0]  alu_sel_o;
   logic        alu_valid_i;
   logic [15:0] alu_data_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic [15:0] rsp_data_o;
   logic [1:0]  rsp_sel_o;
   logic        busy_o;
   logic        proto_err_o;
`ifdef ULA_ISSUER_CHECK_EN
   logic        mismatch_o;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ula_issuer #(.DATA_WIDTH(8), .SEL_WIDTH(2), .RSP_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_a_i(req_a_i), .req_b_i(req_b_i), .req_sel_i(req_sel_i),
      .alu_valid_o(alu_valid_o), .alu_data_1_o(alu_data_1_o),
      .alu_data_2_o(alu_data_2_o), .alu_sel_o(alu_sel_o),
      .alu_valid_i(alu_valid_i), .alu_data_i(alu_data_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_data_o(rsp_data_o), .rsp_sel_o(rsp_sel_o),
      .busy_o(busy_o), .proto_err_o(proto_err_o)
`ifdef ULA_ISSUER_CHECK_EN
      , .mismatch_o(mismatch_o)
`endif
   );

   // Behavioural ula: two register stages, not reset (keeps draining across
   // an issuer reset, like the real datapath).
   logic        s1_v = 1'b0, u_v = 1'b0;
   logic [15:0] s1_d = '0, u_d = '0;
   logic        inj_v = 1'b0;
   logic [15:0] inj_d = '0;
   logic        corrupt = 1'b0;

   function automatic logic [15:0] ula_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] s);
      case (s)
         2'b00:   ula_f = {8'h00, a} + {8'h00, b};
         2'b01:   ula_f = {8'h00, a} - {8'h00, b};
         2'b10:   ula_f = {8'h00, a} + 16'd1;
         default: ula_f = 16'h0000;
      endcase
   endfunction

   always @(posedge clk) begin
      s1_v <= alu_valid_o;
      s1_d <= ula_f(alu_data_1_o, alu_data_2_o, alu_sel_o);
      u_v  <= s1_v;
      u_d  <= s1_d;
   end

   assign alu_valid_i = u_v | inj_v;
   assign alu_data_i  = inj_v ? inj_d : (corrupt ? 16'h0005 : u_d);

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [1:0]  sel;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [8];
   vec_t b2b  [6];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One isolated op: accept at cycle 0, issue cycle 1, response cycle 4.
   task automatic do_op(input int idx, input vec_t v);
      rsp_ready_i = 1'b1;
      req_valid_i = 1'b1;
      req_a_i = v.a; req_b_i = v.b; req_sel_i = v.sel;
      chk("op_ready", {31'd0, req_ready_o}, 32'd1);
      tick;
      req_valid_i = 1'b0;
      chk("op_issue_v", {31'd0, alu_valid_o}, 32'd1);
      chk("op_issue_a", {24'd0, alu_data_1_o}, {24'd0, v.a});
      chk("op_issue_b", {24'd0, alu_data_2_o}, {24'd0, v.b});
      tick;
      chk("op_issue_hold", {23'd0, alu_valid_o, alu_data_1_o}, {24'd0, v.a});
      tick;
      chk("op_rsp_early", {31'd0, rsp_valid_o}, 32'd0);
      tick;
      chk("op_rsp_v", {31'd0, rsp_valid_o}, 32'd1);
      chk("op_rsp_d", {16'd0, rsp_data_o}, {16'd0, v.exp});
      chk("op_rsp_s", {30'd0, rsp_sel_o}, {30'd0, v.sel});
      tick;
      chk("op_idle", {30'd0, rsp_valid_o, busy_o}, 32'd0);
      $display("op %0d a=%02h b=%02h sel=%0d rsp=%04h exp=%04h", idx, v.a, v.b, v.sel,
               rsp_data_o, v.exp);
   endtask

   initial begin
      int acc_n, rsp_n, cyc;
      logic took;

      vecs[0] = '{8'h05, 8'h03, 2'b00, 16'h0008};
      vecs[1] = '{8'h01, 8'h02, 2'b01, 16'hFFFF};
      vecs[2] = '{8'hFF, 8'h00, 2'b10, 16'h0100};
      vecs[3] = '{8'hAB, 8'hCD, 2'b11, 16'h0000};
      vecs[4] = '{8'hFF, 8'hFF, 2'b00, 16'h01FE};
      vecs[5] = '{8'h00, 8'h01, 2'b01, 16'hFFFF};
      vecs[6] = '{8'h10, 8'h05, 2'b01, 16'h000B};
      vecs[7] = '{8'h7F, 8'h00, 2'b10, 16'h0080};

      b2b[0] = '{8'h01, 8'h01, 2'b00, 16'h0002};
      b2b[1] = '{8'h09, 8'h04, 2'b01, 16'h0005};
      b2b[2] = '{8'h03, 8'h07, 2'b01, 16'hFFFC};
      b2b[3] = '{8'h80, 8'h00, 2'b10, 16'h0081};
      b2b[4] = '{8'hAA, 8'h55, 2'b11, 16'h0000};
      b2b[5] = '{8'hFF, 8'h01, 2'b00, 16'h0100};

      // reset state
      tick; tick;
      chk("rst_ready", {31'd0, req_ready_o}, 32'd0);
      chk("rst_outs", {28'd0, alu_valid_o, rsp_valid_o, busy_o, proto_err_o}, 32'd0);
      chk("rst_data", {rsp_data_o, 6'd0, rsp_sel_o, alu_data_1_o}, 32'd0);
      rst_n = 1'b1;
      tick;
      chk("post_rst_ready", {31'd0, req_ready_o}, 32'd1);
      repeat (5) tick;

      // table-driven single ops
      for (int i = 0; i < 8; i++) do_op(i, vecs[i]);
`ifdef ULA_ISSUER_CHECK_EN
      chk("clean_mismatch", {31'd0, mismatch_o}, 32'd0);
`endif

      // back-pressure: 6 requests with responses held off
      rsp_ready_i = 1'b0;
      acc_n = 0; rsp_n = 0; cyc = 0;
      while ((acc_n < 6 || rsp_n < 6) && cyc < 80) begin
         if (cyc == 12) begin
            chk("bp_accepted", acc_n, 4);
            chk("bp_ready_low", {31'd0, req_ready_o}, 32'd0);
            chk("bp_busy", {31'd0, busy_o}, 32'd1);
            rsp_ready_i = 1'b1;
         end
         if (rsp_valid_o && rsp_ready_i) begin
            chk("bp_rsp_d", {16'd0, rsp_data_o}, {16'd0, b2b[rsp_n].exp});
            chk("bp_rsp_s", {30'd0, rsp_sel_o}, {30'd0, b2b[rsp_n].sel});
            $display("bp rsp %0d data=%04h exp=%04h", rsp_n, rsp_data_o, b2b[rsp_n].exp);
            rsp_n++;
         end
         req_valid_i = (acc_n < 6);
         if (acc_n < 6) begin
            req_a_i = b2b[acc_n].a; req_b_i = b2b[acc_n].b; req_sel_i = b2b[acc_n].sel;
         end
         took = req_valid_i & req_ready_o;
         tick;
         if (took) acc_n++;
         cyc++;
      end
      req_valid_i = 1'b0;
      chk("bp_all_acc", acc_n, 6);
      chk("bp_all_rsp", rsp_n, 6);
      tick;
      chk("bp_idle", {30'd0, busy_o, rsp_valid_o}, 32'd0);

      // stray result after the mask window
      chk("pe_before", {30'd0, busy_o, proto_err_o}, 32'd0);
      inj_v = 1'b1; inj_d = 16'h1234;
      tick;
      inj_v = 1'b0;
      chk("pe_set", {31'd0, proto_err_o}, 32'd1);
      chk("pe_no_rsp", {30'd0, rsp_valid_o, busy_o}, 32'd0);
      tick;
      chk("pe_sticky", {31'd0, proto_err_o}, 32'd1);
      $display("proto_err inject proto_err=%0d", proto_err_o);

      // reset with two ops in flight
      req_valid_i = 1'b1; req_a_i = 8'h11; req_b_i = 8'h22; req_sel_i = 2'b00;
      tick;
      req_a_i = 8'h33; req_b_i = 8'h44;
      tick;
      req_valid_i = 1'b0;
      tick;
      rst_n = 1'b0;
      #1;
      chk("mrst_outs", {27'd0, req_ready_o, alu_valid_o, rsp_valid_o, busy_o, proto_err_o},
          32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick;
         chk("mrst_no_rsp", {30'd0, rsp_valid_o, proto_err_o}, 32'd0);
      end
      chk("mrst_busy", {31'd0, busy_o}, 32'd0);
      $display("mid-op reset proto_err=%0d rsp_valid=%0d", proto_err_o, rsp_valid_o);

`ifdef ULA_ISSUER_CHECK_EN
      // corrupted result
      corrupt = 1'b1;
      rsp_ready_i = 1'b1;
      req_valid_i = 1'b1; req_a_i = 8'h02; req_b_i = 8'h02; req_sel_i = 2'b00;
      tick;
      req_valid_i = 1'b0;
      repeat (4) tick;
      corrupt = 1'b0;
      chk("mismatch_set", {31'd0, mismatch_o}, 32'd1);
      $display("corrupt op mismatch=%0d", mismatch_o);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
